// File: rtl/fifo_frame_serializer.sv
// Pops 32-bit words from a show-ahead FIFO and emits a framed byte stream:
// SYNC0, SYNC1, FRAME_WORDS*4 data bytes MSB first, plus an XOR checksum
// byte when FIFO_FRAME_SERIALIZER_CHKSUM_EN is defined.
module fifo_frame_serializer #(
    parameter int          FRAME_WORDS = 64,
    parameter logic [7:0]  SYNC0       = 8'hA5,
    parameter logic [7:0]  SYNC1       = 8'h5A
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    input  logic        enable,
    output logic        fifo_rd_en,
    input  logic        fifo_rd_vld,
    input  logic [31:0] fifo_rd_data,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_sof,
    output logic        m_eof,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int                CNT_W    = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic [2:0] {IDLE, HEAD0, HEAD1, DATA, TAIL} state_t;

    state_t           state;
    logic [31:0]      word_buf;
    logic             buf_full;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_cnt;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
    logic [7:0]       checksum;
`endif

    logic        adv;
    logic        last_in_buf;
    logic        last_data;
    logic        emit;
    logic [31:0] cur_word;
    logic [7:0]  cur_byte;

    assign adv         = !m_valid || m_ready;
    assign last_in_buf = (byte_idx == 2'd3);
    assign last_data   = last_in_buf && (word_cnt == LAST_CNT);

    // A pop is also allowed while the last byte of the buffered word leaves,
    // so a continuous stream refills the buffer without a bubble.
    assign fifo_rd_en = (state == DATA) && (!buf_full || (adv && last_in_buf))
                        && fifo_rd_vld && (word_cnt < LAST_CNT);

    // An empty buffer is bypassed: byte 0 goes out the cycle its word is popped.
    assign cur_word = buf_full ? word_buf : fifo_rd_data;
    assign emit     = (state == DATA) && adv && (buf_full || fifo_rd_en);

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        cur_byte = cur_word[7:0];
        case (byte_idx)
            2'd0:    cur_byte = cur_word[31:24];
            2'd1:    cur_byte = cur_word[23:16];
            2'd2:    cur_byte = cur_word[15:8];
            default: cur_byte = cur_word[7:0];
        endcase
    end

    // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state     <= IDLE;
            word_buf  <= '0;
            buf_full  <= 1'b0;
            byte_idx  <= 2'd0;
            word_cnt  <= '0;
            m_data    <= 8'h00;
            m_valid   <= 1'b0;
            m_sof     <= 1'b0;
            m_eof     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'h0000;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
            checksum  <= 8'h00;
`endif
        end else begin
            if (m_valid && m_ready && m_eof)
                frame_cnt <= frame_cnt + 16'd1;

            if (fifo_rd_en) begin
                word_buf <= fifo_rd_data;
                word_cnt <= word_cnt + CNT_W'(1);
            end

            // Accepted or empty output slot drains unless a state below refills it.
            if (adv) begin
                m_valid <= 1'b0;
                m_sof   <= 1'b0;
                m_eof   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && fifo_rd_vld) begin
                        state <= HEAD0;
                        busy  <= 1'b1;
                    end
                end
                HEAD0: begin
                    if (adv) begin
                        m_data  <= SYNC0;
                        m_valid <= 1'b1;
                        m_sof   <= 1'b1;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
                        checksum <= 8'h00;
`endif
                        state   <= HEAD1;
                    end
                end
                HEAD1: begin
                    if (adv) begin
                        m_data  <= SYNC1;
                        m_valid <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (emit) begin
                        m_data  <= cur_byte;
                        m_valid <= 1'b1;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
                        checksum <= checksum ^ cur_byte;
`endif
                        if (last_in_buf) begin
                            byte_idx <= 2'd0;
                            buf_full <= fifo_rd_en;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            buf_full <= 1'b1;
                        end
                        if (last_data) begin
                            word_cnt <= '0;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
                            state    <= TAIL;
`else
                            m_eof    <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
`endif
                        end
                    end else if (fifo_rd_en) begin
                        buf_full <= 1'b1;
                    end
                end
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
                TAIL: begin
                    if (adv) begin
                        m_data  <= checksum;
                        m_valid <= 1'b1;
                        m_eof   <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_serializer.sv
// Self-checking bench for fifo_frame_serializer: show-ahead FIFO model, frame-level
// byte reference model, directed scenarios and a randomized backpressure run.
module tb_fifo_frame_serializer;

    localparam int FW = 2;
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int LEN = FW * 4 + 2 + CHK;
    localparam int NF  = 40;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        enable;
    logic        fifo_rd_en;
    logic        fifo_rd_vld;
    logic [31:0] fifo_rd_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eof;
    logic        busy;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] model_words[$];
    int          pos = 0;
    logic [7:0]  model_chk = 8'h00;
    int          exp_frames = 0;
    int          pop_total = 0;
    bit          pop_pending = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_sof;
    logic        prev_eof;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];

    fifo_frame_serializer #(.FRAME_WORDS(FW), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void drive_fifo();
        fifo_rd_vld  = (fifo_q.size() != 0);
        fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endfunction

    // Frame byte at position p: two sync bytes, words MSB first, then XOR of data bytes.
    function automatic logic [7:0] model_byte(input int p);
        int          d;
        logic [31:0] w;
        d = p - 2;
        if (p == 0) return 8'hA5;
        if (p == 1) return 8'h5A;
        if (d < FW * 4) begin
            w = (d / 4 < model_words.size()) ? model_words[d / 4] : 32'h0;
            return w[8 * (3 - d % 4) +: 8];
        end
        return model_chk;
    endfunction

    always @(negedge rd_clk) begin
        if (!rd_rst_n) begin
            pop_pending = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            pop_pending = fifo_rd_en;
            if (fifo_rd_en) begin
                pop_total++;
                check("pop_needs_vld", fifo_rd_vld, 1);
            end
            check("frame_cnt", frame_cnt, exp_frames[15:0]);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_sof", m_sof, prev_sof);
                check("stall_eof", m_eof, prev_eof);
            end
            if (m_valid && m_ready) begin
                if (pos >= 2 && pos < 2 + FW * 4)
                    check("word_present", ((pos - 2) / 4 < model_words.size()), 1);
                check("byte", m_data, model_byte(pos));
                check("sof", m_sof, pos == 0);
                check("eof", m_eof, pos == LEN - 1);
                got.push_back(m_data);
                if (pos == 0) model_chk = 8'h00;
                if (pos >= 2 && pos < 2 + FW * 4) model_chk = model_chk ^ model_byte(pos);
                pos++;
                if (pos == LEN) begin
                    pos = 0;
                    exp_frames++;
                    repeat (FW) if (model_words.size() != 0) void'(model_words.pop_front());
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_sof   = m_sof;
            prev_eof   = m_eof;
        end
    end

    task automatic step();
        @(posedge rd_clk);
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic rstep();
        step();
        m_ready = ($urandom_range(0, 3) != 0);
        enable  = ($urandom_range(0, 7) != 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        model_words.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        fifo_q.delete();
        model_words.delete();
        pos        = 0;
        model_chk  = 8'h00;
        exp_frames = 0;
        drive_fifo();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_sof"}, m_sof, 0);
        check({tag, "_m_eof"}, m_eof, 0);
        check({tag, "_m_data"}, m_data, 8'h00);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 16'h0000);
        check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    endtask

    // mode 0: m_ready held high, 1: toggled every cycle, 2: random.
    task automatic wait_frames(input int target, input int budget, input int mode);
        int n;
        n = 0;
        while (exp_frames < target && n < budget) begin
            if (mode == 2) rstep();
            else begin
                step();
                if (mode == 1) m_ready = ~m_ready;
            end
            n++;
        end
        check("frame_timeout", exp_frames >= target, 1);
    endtask

    task automatic compare_got(input string name);
        check({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check(name, got[i], exp_q[i]);
    endtask

    initial begin
        int p0;
        int f0;
        int n;

        rd_rst_n = 1'b0;
        enable   = 1'b0;
        m_ready  = 1'b0;
        drive_fifo();
        #2;
        check_reset_outputs("reset");
        repeat (3) step();
        rd_rst_n = 1'b1;
        step();

        // Basic frame, downstream always ready.
        enable = 1'b1;
        m_ready = 1'b1;
        got.delete();
        p0 = pop_total;
        push_word(32'h01020304);
        push_word(32'h05060708);
        wait_frames(1, 200, 0);
        step();
        step();
        exp_q = '{8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
        exp_q.push_back(8'h08);
`endif
        compare_got("t1_bytes");
        check("t1_pops", pop_total - p0, 2);
        check("t1_frame_cnt", frame_cnt, 16'd1);
        check("t1_busy", busy, 0);

        // Same shape with m_ready toggling every cycle.
        got.delete();
        p0 = pop_total;
        push_word(32'h11223344);
        push_word(32'h55667788);
        wait_frames(2, 400, 1);
        m_ready = 1'b1;
        step();
        step();
        exp_q = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
        exp_q.push_back(8'h88);
`endif
        compare_got("t2_bytes");
        check("t2_pops", pop_total - p0, 2);
        check("t2_frame_cnt", frame_cnt, 16'd2);

        // Underflow mid-frame: second word arrives late.
        got.delete();
        push_word(32'hCAFEF00D);
        repeat (20) step();
        check("t3_valid_low", m_valid, 0);
        check("t3_busy_wait", busy, 1);
        check("t3_partial_len", got.size(), 6);
        push_word(32'h12345678);
        wait_frames(3, 200, 0);
        step();
        exp_q = '{8'hA5, 8'h5A, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
        exp_q.push_back(8'hC1);
`endif
        compare_got("t3_bytes");

        // enable dropped while SYNC0 is stalled (FSM in HEAD1).
        got.delete();
        m_ready = 1'b0;
        push_word(32'hA1A2A3A4);
        push_word(32'hB1B2B3B4);
        push_word(32'hC1C2C3C4);
        push_word(32'hD1D2D3D4);
        n = 0;
        while (!(m_valid && m_sof) && n < 50) begin
            step();
            n++;
        end
        check("t4_reached_head1", m_valid && m_sof, 1);
        enable = 1'b0;
        m_ready = 1'b1;
        wait_frames(4, 200, 0);
        repeat (10) step();
        check("t4_busy", busy, 0);
        check("t4_valid", m_valid, 0);
        check("t4_words_left", fifo_q.size(), 2);
        check("t4_frame_cnt", frame_cnt, 16'd4);
        exp_q = '{8'hA5, 8'h5A, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
`ifdef FIFO_FRAME_SERIALIZER_CHKSUM_EN
        exp_q.push_back(8'h00);
`endif
        compare_got("t4_bytes");

        // Reset pulsed in the middle of the data phase.
        got.delete();
        enable = 1'b1;
        n = 0;
        while (got.size() < 4 && n < 50) begin
            step();
            n++;
        end
        check("t5_in_data", got.size() >= 4, 1);
        rd_rst_n = 1'b0;
        #2;
        check_reset_outputs("t5_reset");
        model_reset();
        step();
        step();
        rd_rst_n = 1'b1;
        push_word(32'h0F1E2D3C);
        push_word(32'h4B5A6978);
        n = 0;
        while (!m_valid && n < 50) begin
            step();
            n++;
        end
        check("t5_restart_data", m_data, 8'hA5);
        check("t5_restart_sof", m_sof, 1);
        wait_frames(1, 200, 0);

        // Randomized words, gaps, backpressure and enable.
        f0 = exp_frames;
        for (int fr = 0; fr < NF; fr++) begin
            for (int wi = 0; wi < FW; wi++) begin
                push_word($urandom);
                repeat ($urandom_range(0, 5)) rstep();
            end
        end
        wait_frames(f0 + NF, 4000, 2);
        m_ready = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        check("rand_fifo_empty", fifo_q.size(), 0);
        check("rand_busy", busy, 0);
        check("rand_valid", m_valid, 0);
        check("rand_frame_cnt", frame_cnt, 16'(f0 + NF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_frame_serializer.md
Name: fifo_frame_serializer

Overview:
- Downstream consumer of the 1024x32b prefetch (show-ahead) async FIFO, running in the FIFO read-clock domain.
- Pops 32-bit words and emits an 8-bit valid/ready byte stream framed as: 2 sync bytes, then FRAME_WORDS*4 data bytes, then an optional XOR checksum byte.
- Feeds the byte-oriented transmit path (UART/ETH MAC byte interface).

Parameters:
FRAME_WORDS, 64, 32-bit words per frame; legal range 1..4096.
SYNC0, 8'hA5, first header byte.
SYNC1, 8'h5A, second header byte.

Ports:
rd_clk  input  1  read-domain clock; same clock as the FIFO read side.
rd_rst_n  input  1  reset, asynchronous assert, active-low.
enable  input  1  allow new frames to start; sampled only in IDLE.
fifo_rd_en  output  1  pop strobe to the FIFO.
fifo_rd_vld  input  1  FIFO head word valid (show-ahead).
fifo_rd_data  input  32  FIFO head word.
m_data  output  8  output byte.
m_valid  output  1  output byte valid.
m_ready  input  1  downstream accepts byte.
m_sof  output  1  first byte of frame (SYNC0).
m_eof  output  1  last byte of frame.
busy  output  1  high in any state other than IDLE.
frame_cnt  output  16  completed frames; wraps 16'hFFFF -> 0.

Behaviour:
- Reset: state=IDLE; m_valid, m_sof, m_eof, fifo_rd_en, busy = 0; m_data=0; frame_cnt=0; word buffer empty; checksum=0.
- Output stage is one register. Define adv = !m_valid | m_ready.
- While m_valid & !m_ready, m_data, m_sof and m_eof stay stable.
- On adv with no new byte available, m_valid drops to 0 next cycle.
- FSM states: IDLE, HEAD0, HEAD1, DATA, TAIL.
- IDLE -> HEAD0 when enable & fifo_rd_vld. A frame never starts without at least one word present.
- HEAD0: on adv, load SYNC0 with sof=1, go to HEAD1. checksum cleared.
- HEAD1: on adv, load SYNC1, go to DATA.
- DATA, pop rule: fifo_rd_en = (state==DATA) & !buf_full & fifo_rd_vld & word_cnt<FRAME_WORDS. This is combinational, one cycle wide per pop. fifo_rd_data is captured into word_buf in that same cycle, and buf_full is set.
- DATA, byte emission: on adv & buf_full, load byte word_buf[31:24], then [23:16], then [15:8], then [7:0]. This is MSB first, 2-bit byte_idx.
  - Each emitted byte is XORed into checksum.
  - After byte 3, buf_full is cleared.
  - Next-pop lookahead is allowed in that cycle, so a back-to-back stream has no bubble.
- Underflow mid-frame (buf empty, fifo_rd_vld=0): m_valid goes low after the current byte is accepted. The FSM waits in DATA with no timeout. The frame resumes when fifo_rd_vld returns.
- Last data byte (word FRAME_WORDS-1, byte 3): go to TAIL (see Optional Feature).
- TAIL: on adv, load checksum with eof=1, then go to IDLE.
- frame_cnt increments on the cycle m_valid & m_ready & m_eof.
- enable deasserted mid-frame has no effect; the current frame completes.
- rd_rst_n assertion mid-frame aborts immediately to reset values. No partial frame is replayed. Words already popped are lost.
- Minimum throughput: 1 byte/clk when m_ready=1 and the FIFO is non-empty.

Optional Feature:
- Macro: FIFO_FRAME_SERIALIZER_CHKSUM_EN.
- Defined: TAIL state exists. Frame length is FRAME_WORDS*4+3 bytes, and eof is on the checksum byte.
- Undefined: TAIL and the checksum logic are removed. The last data byte carries eof=1 and the FSM goes DATA -> IDLE. Frame length is FRAME_WORDS*4+2.

Test Plan:
1. Macro defined, FRAME_WORDS=2, FIFO holds 0x01020304 and 0x05060708, enable=1, m_ready=1 -> bytes A5 5A 01 02 03 04 05 06 07 08 08; sof on A5, eof on final 08; exactly 2 fifo_rd_en pulses; frame_cnt=1.
2. Same stimulus with m_ready toggling 1/0 every cycle -> identical byte sequence; m_data stable during every stalled cycle; no byte dropped or duplicated.
3. FRAME_WORDS=2, only the first word present until 20 cycles later -> m_valid low after byte 04; FSM remains in DATA (busy=1); bytes 05..08 and checksum follow once the second word arrives.
4. enable dropped during HEAD1 with 4 words queued -> current frame completes; FSM stays in IDLE; remaining words not popped; busy=0.
5. rd_rst_n pulsed low during DATA -> next cycle all outputs are at reset values and frame_cnt=0. After release with enable=1 and a word present, the next frame starts with A5 / sof=1.
6. Macro undefined, FRAME_WORDS=1, word 0xDEADBEEF -> bytes A5 5A DE AD BE EF; eof on EF; 6 bytes total.
